// File: rtl/uart_tx_block.sv
// rtl/uart_tx_block.sv - 8N1 UART transmitter with one-deep holding buffer (optional even parity: UART_TX_PARITY_EN)
module uart_tx_block #(
    parameter int BIT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       data_write,
    output logic       serial_out,
    output logic       buffer_full,
    output logic       tx_active,
    output logic       write_error
);
    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(BIT_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_buf;
    logic            r_full, r_err, r_serial;
    logic            w_serial_nxt, w_tick, w_unload, w_accept;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
`endif

    assign w_tick   = (r_timer == LAST_TICK);
    // A write may land on the same edge that empties the buffer.
    assign w_accept = data_write && (!r_full || w_unload);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = w_tick ? '0 : r_timer + 1'b1;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_unload     = 1'b0;
        w_serial_nxt = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (r_full) begin
                    w_unload    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_full) begin
                        w_unload    = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_unload) w_shift_nxt = r_buf;
        // Line level is computed for the coming state so serial_out stays a pure flop.
        case (w_state_nxt)
            S_START:  w_serial_nxt = 1'b0;
            S_DATA:   w_serial_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_serial_nxt = r_par;
`endif
            default:  w_serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_idx    <= 3'd0;
            r_shift  <= 8'd0;
            r_buf    <= 8'd0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
            r_serial <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_serial <= w_serial_nxt;
            if (w_accept) begin
                r_buf  <= tx_data;
                r_full <= 1'b1;
                r_err  <= 1'b0;
            end else begin
                if (w_unload)   r_full <= 1'b0;
                if (data_write) r_err  <= 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        r_par <= 1'b0;
        else if (w_unload) r_par <= ^r_buf;
    end
`endif

    assign serial_out  = r_serial;
    assign buffer_full = r_full;
    assign tx_active   = (r_state != S_IDLE);
    assign write_error = r_err;
endmodule

// File: tb/tb_uart_tx_block.sv
// tb/tb_uart_tx_block.sv - directed and random checks of uart_tx_block against a frame-timing model
module tb_uart_tx_block;
    localparam int BP = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       data_write;
    logic       serial_out, buffer_full, tx_active, write_error;

    uart_tx_block #(.BIT_PERIOD(BP)) dut (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .data_write(data_write),
        .serial_out(serial_out), .buffer_full(buffer_full),
        .tx_active(tx_active), .write_error(write_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: a frame is a start edge plus the byte; everything else follows from arithmetic on cycles.
    bit         m_act, m_full, m_err;
    int         m_start;
    logic [7:0] m_byte, m_buf;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_act = 0; m_full = 0; m_err = 0; m_start = 0; m_byte = 0; m_buf = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] d);
        bit ending, unload, acc;
        ending = m_act && (cyc - m_start == FL * BP);
        unload = m_full && (!m_act || ending);
        acc    = wr && (!m_full || unload);
        if (ending) m_act = 0;
        if (unload) begin
            m_act = 1; m_start = cyc; m_byte = m_buf; m_full = 0;
        end
        if (acc) begin
            m_buf = d; m_full = 1; m_err = 0;
        end else if (wr) begin
            m_err = 1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("serial_out", serial_out,
            m_act ? frame_bit(m_byte, (cyc - m_start) / BP) : 1'b1);
        chk("buffer_full", buffer_full, m_full);
        chk("tx_active", tx_active, m_act);
        chk("write_error", write_error, m_err);
    endtask

    task automatic tick(input bit wr, input logic [7:0] d);
        data_write = wr;
        tx_data    = d;
        @(posedge clk);
        cyc++;
        model_edge(wr, d);
        #1;
        check_all();
        data_write = 1'b0;
        tx_data    = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    int rise, fall, wcyc;

    initial begin
        n_rst = 1'b0; data_write = 1'b0; tx_data = 8'h00;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        n_rst = 1'b1;

        // Single frame 0xA5 from idle; directed latency and length checks
        tick(1'b1, 8'hA5);
        wcyc = cyc; rise = -1; fall = -1;
        for (int i = 0; i < 300 && fall < 0; i++) begin
            tick(1'b0, 8'h00);
            if (tx_active && rise < 0) rise = cyc;
            if (!tx_active && rise >= 0 && fall < 0) fall = cyc;
        end
        chk_int("a5_start_latency", rise - wcyc, 1);
        chk_int("a5_active_len", fall - rise, FL * BP);
        idle(5);

        // Back-to-back frames
        tick(1'b1, 8'h55);
        idle(20);
        tick(1'b1, 8'h0F);
        idle(2 * FL * BP + 10);

        // Overrun drops 0x33; 0x44 later clears the flag
        tick(1'b1, 8'h11);
        idle(5);
        tick(1'b1, 8'h22);
        idle(10);
        tick(1'b1, 8'h33);
        chk("overrun_flag", write_error, 1'b1);
        idle(FL * BP + 10);
        tick(1'b1, 8'h44);
        chk("overrun_cleared", write_error, 1'b0);
        idle(2 * FL * BP + 10);

        // Write on the exact unload edge at the end of a stop bit
        tick(1'b1, 8'hA1);
        idle(3);
        tick(1'b1, 8'hB2);
        while (cyc + 1 != m_start + FL * BP) tick(1'b0, 8'h00);
        tick(1'b1, 8'hC3);
        chk("unload_edge_no_err", write_error, 1'b0);
        chk("unload_edge_full", buffer_full, 1'b1);
        idle(3 * FL * BP + 10);

        // Reset in the middle of data bit 3 with a buffered byte and the error flag set
        tick(1'b1, 8'hC3);
        idle(2);
        tick(1'b1, 8'h5A);
        tick(1'b1, 8'h99);
        while (cyc - m_start != 4 * BP + 5) tick(1'b0, 8'h00);
        n_rst = 1'b0;
        #2;
        model_reset();
        chk("rst_serial", serial_out, 1'b1);
        chk("rst_full", buffer_full, 1'b0);
        chk("rst_active", tx_active, 1'b0);
        chk("rst_err", write_error, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        tick(1'b1, 8'h3C);
        idle(FL * BP + 10);

        // 0x07: parity bit is 1 when enabled
        tick(1'b1, 8'h07);
        wcyc = cyc; rise = -1; fall = -1;
        for (int i = 0; i < 300 && fall < 0; i++) begin
            tick(1'b0, 8'h00);
            if (tx_active && rise < 0) rise = cyc;
            if (!tx_active && rise >= 0 && fall < 0) fall = cyc;
            if (rise >= 0 && fall < 0 && cyc - rise == 9 * BP + 2)
                chk("bit9_level", serial_out, (FL == 11) ? 1'b1 : 1'b1);
        end
        chk_int("07_active_len", fall - rise, FL * BP);
        idle(5);

        // Random writes against the model
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 39) == 0, 8'($urandom));
        idle(3 * FL * BP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
